// File: rtl/clocked_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : clocked_delay_line
//  Brief    : Clocked multi-tap delay line. A rising edge on trig launches a
//             staggered train of active-low pulses, one per tap, with
//             busy/done status and an optional retrigger mode.
//  Revision : 1.0 - initial release
// ============================================================================
module clocked_delay_line #(
    parameter int NTAPS     = 5,
    parameter int STEP      = 2,
    parameter int PULSE     = 1,
    parameter int RETRIGGER = 0,
    parameter int CW        = $clog2(NTAPS*STEP+PULSE+1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             trig,
    output logic [NTAPS-1:0] tap_n,
    output logic             busy,
    output logic             done
);

    // Reject nonsensical geometries at elaboration time.
    generate
        if (NTAPS < 1 || NTAPS > 16 || STEP < 1 || PULSE < 1) begin : g_param_err
            $error("clocked_delay_line: illegal NTAPS/STEP/PULSE");
        end
    endgenerate

    // Counter value on the edge that finishes a sequence.
    localparam logic [CW-1:0] END_CNT = CW'(NTAPS*STEP+PULSE);
    localparam logic [CW-1:0] ONE_CNT = CW'(1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             trig_q;
    logic [NTAPS-1:0] tap_n_q, tap_n_d;
    logic             done_q, done_d;

    logic             complete;
    logic             busy_eff;
    logic             retrig_ok;
    logic             accept;

    // The completing edge counts as not busy so back-to-back launches work.
    assign complete  = (state_q == RUN) && (cnt_q == END_CNT);
    assign busy_eff  = (state_q == RUN) && !complete;
    assign retrig_ok = (RETRIGGER != 0);
    assign accept    = en && trig && !trig_q && (!busy_eff || retrig_ok);

    // Next-state, counter and completion decode.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        done_d  = complete;
        if (accept) begin
            state_d = RUN;
            cnt_d   = ONE_CNT;
        end else if (busy_eff) begin
            state_d = RUN;
            cnt_d   = cnt_q + ONE_CNT;
        end else begin
            state_d = IDLE;
        end
    end

    // Tap k is low while the next count lies in [k*STEP+1, k*STEP+PULSE];
    // decoding the next count keeps the taps registered yet cycle-exact.
    genvar k;
    generate
        for (k = 1; k <= NTAPS; k++) begin : g_tap
            localparam logic [CW-1:0] LO = CW'(k*STEP+1);
            localparam logic [CW-1:0] HI = CW'(k*STEP+PULSE);
            assign tap_n_d[k-1] = !((cnt_d >= LO) && (cnt_d <= HI));
        end
    endgenerate

    // State register; trig_q resets high so a held trig is not an edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            trig_q  <= 1'b1;
            tap_n_q <= '1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig;
            tap_n_q <= tap_n_d;
            done_q  <= done_d;
        end
    end

    assign tap_n = tap_n_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_clocked_delay_line.sv
`default_nettype none
// ============================================================================
//  Module   : tb_clocked_delay_line
//  Brief    : Directed self-checking bench for clocked_delay_line, covering
//             default, retrigger and overlapping-window configurations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_clocked_delay_line;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic       trig;

    logic [4:0] tap_def;
    logic       busy_def, done_def;
    logic [4:0] tap_rt;
    logic       busy_rt, done_rt;
    logic [2:0] tap_sm;
    logic       busy_sm, done_sm;

    int n_assert = 0;
    int n_fail   = 0;

    // Defaults: {tap_n[4:0], busy, done} after edge E+t, t = 0..12.
    localparam logic [6:0] EXP_DEF [0:12] = '{
        7'b11111_1_0, 7'b11111_1_0, 7'b11110_1_0, 7'b11111_1_0,
        7'b11101_1_0, 7'b11111_1_0, 7'b11011_1_0, 7'b11111_1_0,
        7'b10111_1_0, 7'b11111_1_0, 7'b01111_1_0, 7'b11111_0_1,
        7'b11111_0_0
    };
    // NTAPS=3, STEP=1, PULSE=3: {tap_n[2:0], busy, done}, t = 0..7.
    localparam logic [4:0] EXP_SM [0:7] = '{
        5'b111_1_0, 5'b110_1_0, 5'b100_1_0, 5'b000_1_0,
        5'b001_1_0, 5'b011_1_0, 5'b111_0_1, 5'b111_0_0
    };
    localparam logic [6:0] IDLE5 = 7'b11111_0_0;
    localparam logic [4:0] IDLE3 = 5'b111_0_0;

    clocked_delay_line u_def (
        .clk(clk), .reset_n(reset_n), .en(en), .trig(trig),
        .tap_n(tap_def), .busy(busy_def), .done(done_def)
    );

    clocked_delay_line #(.RETRIGGER(1)) u_rt (
        .clk(clk), .reset_n(reset_n), .en(en), .trig(trig),
        .tap_n(tap_rt), .busy(busy_rt), .done(done_rt)
    );

    clocked_delay_line #(.NTAPS(3), .STEP(1), .PULSE(3)) u_sm (
        .clk(clk), .reset_n(reset_n), .en(en), .trig(trig),
        .tap_n(tap_sm), .busy(busy_sm), .done(done_sm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp_v);
        end
    endtask

    function automatic logic [6:0] def_at(input int t);
        if (t >= 0 && t <= 12) return EXP_DEF[t];
        return IDLE5;
    endfunction

    function automatic logic [4:0] sm_at(input int t);
        if (t >= 0 && t <= 7) return EXP_SM[t];
        return IDLE3;
    endfunction

    initial begin
        // Reset with trig held high, then release: nothing may start.
        reset_n = 1'b0;
        en      = 1'b1;
        trig    = 1'b1;
        tick();
        tick();
        chk("reset_def", {1'b0, tap_def, busy_def, done_def}, {1'b0, IDLE5});
        chk("reset_rt",  {1'b0, tap_rt,  busy_rt,  done_rt},  {1'b0, IDLE5});
        chk("reset_sm",  {3'b0, tap_sm,  busy_sm,  done_sm},  {3'b0, IDLE3});
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("held_trig_def_%0d", i), {1'b0, tap_def, busy_def, done_def}, {1'b0, IDLE5});
            chk($sformatf("held_trig_sm_%0d", i),  {3'b0, tap_sm,  busy_sm,  done_sm},  {3'b0, IDLE3});
        end
        trig = 1'b0;
        tick();

        // Single edge: full timing for all three configurations.
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int t = 0; t <= 12; t++) begin
            chk($sformatf("seq_def_t%0d", t), {1'b0, tap_def, busy_def, done_def}, {1'b0, def_at(t)});
            chk($sformatf("seq_rt_t%0d", t),  {1'b0, tap_rt,  busy_rt,  done_rt},  {1'b0, def_at(t)});
            chk($sformatf("seq_sm_t%0d", t),  {3'b0, tap_sm,  busy_sm,  done_sm},  {3'b0, sm_at(t)});
            tick();
        end

        // Second edge at E+5: ignored by default, restarts with RETRIGGER=1.
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int t = 0; t <= 17; t++) begin
            chk($sformatf("rtg_def_t%0d", t), {1'b0, tap_def, busy_def, done_def}, {1'b0, def_at(t)});
            chk($sformatf("rtg_rt_t%0d", t),  {1'b0, tap_rt,  busy_rt,  done_rt},
                {1'b0, (t < 5) ? def_at(t) : def_at(t - 5)});
            if (t == 4) trig = 1'b1;
            if (t == 5) trig = 1'b0;
            tick();
        end

        // Reset asserted for the single edge E+5 aborts the sequence.
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int t = 0; t <= 12; t++) begin
            chk($sformatf("abort_def_t%0d", t), {1'b0, tap_def, busy_def, done_def},
                {1'b0, (t < 5) ? def_at(t) : IDLE5});
            if (t == 4) reset_n = 1'b0;
            if (t == 5) reset_n = 1'b1;
            tick();
        end

        // Edge while disabled is consumed, not deferred.
        en   = 1'b0;
        trig = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("en_off_def_%0d", i), {1'b0, tap_def, busy_def, done_def}, {1'b0, IDLE5});
        end
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("en_late_def_%0d", i), {1'b0, tap_def, busy_def, done_def}, {1'b0, IDLE5});
            chk($sformatf("en_late_sm_%0d", i),  {3'b0, tap_sm,  busy_sm,  done_sm},  {3'b0, IDLE3});
        end
        trig = 1'b0;
        tick();

        // Fresh edge, then a back-to-back edge on the completing edge E+11.
        trig = 1'b1;
        tick();
        trig = 1'b0;
        for (int t = 0; t <= 14; t++) begin
            logic [6:0] e;
            case (t)
                11:      e = 7'b11111_1_1;
                12:      e = 7'b11111_1_0;
                13:      e = 7'b11110_1_0;
                14:      e = 7'b11111_1_0;
                default: e = def_at(t);
            endcase
            chk($sformatf("b2b_def_t%0d", t), {1'b0, tap_def, busy_def, done_def}, {1'b0, e});
            chk($sformatf("b2b_rt_t%0d", t),  {1'b0, tap_rt,  busy_rt,  done_rt},  {1'b0, e});
            if (t == 10) trig = 1'b1;
            if (t == 11) trig = 1'b0;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
